pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage 16-bit WISC-SP20 core. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves four conditions:
- load-use hazards, by inserting one bubble;
- taken branches and jumps resolved in EX, by squashing the two younger instructions;
- data-memory wait states, by freezing the pipeline with a timeout watchdog;
- HALT, by draining the pipeline and parking it.

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage WISC-SP20 pipeline:
//            load-use bubbles, EX redirects, memory wait states, HALT drain.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_halt,
    input  logic [2:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic        err,
    output logic [15:0] bubble_cnt
);

    localparam logic [7:0] c_mem_timeout = 8'(MEM_TIMEOUT);
    localparam logic [3:0] c_drain_init  = 4'(DRAIN_CYCLES - 1);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
        $error("pipe_hazard_ctrl: MEM_TIMEOUT out of range 1..255");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain_cycles
        $error("pipe_hazard_ctrl: DRAIN_CYCLES out of range 1..15");
    end

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [3:0]  r_drain_cnt;
    logic        r_err;
    logic [15:0] r_bubble_cnt;

    logic w_lu;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_halted;
    logic w_bubble;
    logic w_enter_drain;

    assign w_lu = ex_mem_read & ex_reg_write &
                  ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

    always_comb begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_halted      = 1'b0;
        w_bubble      = 1'b0;
        w_enter_drain = 1'b0;
        unique case (r_state)
            S_RUN, S_WAIT: begin
                // A WAIT exit re-evaluates the held EX/ID contents like RUN.
                if (!mem_busy) begin
                    w_pc_en    = 1'b1;
                    w_ifid_en  = 1'b1;
                    w_idex_en  = 1'b1;
                    w_exmem_en = 1'b1;
                    if (ex_redirect) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_lu) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                        w_bubble     = 1'b1;
                    end else if (id_halt) begin
                        w_pc_en       = 1'b0;
                        w_ifid_flush  = 1'b1;
                        w_enter_drain = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_ifid_en    = 1'b1;
                w_ifid_flush = 1'b1;
                w_idex_en    = ~mem_busy;
                w_exmem_en   = ~mem_busy;
            end
            S_HALTED: begin
                w_halted = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_RUN;
            r_wait_cnt   <= 8'd0;
            r_drain_cnt  <= 4'd0;
            r_err        <= 1'b0;
            r_bubble_cnt <= 16'd0;
        end else begin
            if (w_bubble && r_bubble_cnt != 16'hFFFF) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
            unique case (r_state)
                S_RUN: begin
                    if (mem_busy) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= 8'd1;
                    end else if (w_enter_drain) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= c_drain_init;
                    end
                end
                S_WAIT: begin
                    if (mem_busy) begin
                        if (r_wait_cnt != 8'hFF) begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                        if (r_wait_cnt == c_mem_timeout) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= 8'd0;
                        if (w_enter_drain) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= c_drain_init;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!mem_busy) begin
                        if (r_drain_cnt == 4'd0) begin
                            r_state <= S_HALTED;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 4'd1;
                        end
                    end
                end
                S_HALTED: ;
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Every output is held low for as long as reset is asserted.
    assign pc_en      = rst & w_pc_en;
    assign ifid_en    = rst & w_ifid_en;
    assign idex_en    = rst & w_idex_en;
    assign exmem_en   = rst & w_exmem_en;
    assign ifid_flush = rst & w_ifid_flush;
    assign idex_flush = rst & w_idex_flush;
    assign halted     = rst & w_halted;
    assign err        = rst & r_err;
    assign bubble_cnt = rst ? r_bubble_cnt : 16'd0;

endmodule
`default_nettype wire
